// File: rtl/dds_sweep_pkg.sv
// Shared constants for the DDS frequency sweep controller: FSM state
// encoding, sweep mode codes and default widths.
package dds_sweep_pkg;

  localparam int FREQ_BIT_DEF  = 26;
  localparam int DWELL_BIT_DEF = 24;

  // Sweep FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Sweep modes; code 3 is reserved and behaves as single
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter. A load of D (D >= 1) makes expire pulse on
// the D-th cycle after the load edge. A load in the expiring cycle restarts
// the count seamlessly. The counter idles at zero, where expire stays low.
module dds_dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DWELL_BIT = DWELL_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DWELL_BIT-1:0] load_val,
  output logic                 expire
);

  logic [DWELL_BIT-1:0] cnt;

  assign expire = (cnt == DWELL_BIT'(1));

  // Count down once per cycle; clear wins over load, load wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DWELL_BIT'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller feeding the DDS core. It steps freq_ctrl from
// f_start toward f_stop in f_step increments and holds each point for the
// dwell time. Single, sawtooth and triangle sweeps are supported. Each step
// and each endpoint is clamped so the endpoint is always presented exactly
// once per pass.
//
// Request semantics: start is a one-cycle request that is accepted only
// when the FSM is IDLE. Outside IDLE it is dropped with no side effect.
// stop_req is accepted in every state and always wins over start. Both are
// sampled on the rising sclk edge, and the response is visible on the
// outputs in the following cycle.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int FREQ_BIT  = FREQ_BIT_DEF,
  parameter int DWELL_BIT = DWELL_BIT_DEF
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop_req,
  input  logic [1:0]           mode,
  input  logic [FREQ_BIT-1:0]  f_start,
  input  logic [FREQ_BIT-1:0]  f_stop,
  input  logic [FREQ_BIT-1:0]  f_step,
  input  logic [DWELL_BIT-1:0] dwell,
  output logic [FREQ_BIT-1:0]  freq_ctrl,
  output logic                 dds_en,
  output logic                 sweep_busy,
  output logic                 step_strobe,
  output logic                 sweep_done,
  output logic [1:0]           state_dbg
);

  logic [1:0]           state;
  logic [1:0]           cfg_mode;
  logic [FREQ_BIT-1:0]  cfg_start;
  logic [FREQ_BIT-1:0]  cfg_stop;
  logic [FREQ_BIT-1:0]  cfg_step;
  logic [DWELL_BIT-1:0] cfg_dwell;
  logic                 cfg_up;     // f_stop above f_start
  logic                 cfg_degen;  // zero step or zero span: one point only
  logic                 fwd;        // current pass heads toward f_stop

  logic [DWELL_BIT-1:0] dwell_eff;
  logic [FREQ_BIT-1:0]  cur_tgt;
  logic                 cur_up;
  logic                 at_target;
  logic                 end_sweep;
  logic [FREQ_BIT-1:0]  nxt_freq;
  logic                 nxt_fwd;
  logic                 start_ok;
  logic                 step_go;
  logic                 expire;

  assign state_dbg = state;

  // One step toward tgt, computed one bit wider so that overflow and
  // underflow both clamp to the target instead of wrapping.
  function automatic logic [FREQ_BIT-1:0] step_clamp(
    input logic [FREQ_BIT-1:0] cur,
    input logic [FREQ_BIT-1:0] stp,
    input logic [FREQ_BIT-1:0] tgt,
    input logic                up
  );
    logic [FREQ_BIT:0] r;
    if (up) begin
      r = {1'b0, cur} + {1'b0, stp};
      step_clamp = (r >= {1'b0, tgt}) ? tgt : r[FREQ_BIT-1:0];
    end else begin
      r = {1'b0, cur} - {1'b0, stp};
      step_clamp = (r[FREQ_BIT] || (r[FREQ_BIT-1:0] <= tgt)) ? tgt : r[FREQ_BIT-1:0];
    end
  endfunction

  assign dwell_eff = (dwell == '0) ? DWELL_BIT'(1) : dwell;
  assign start_ok  = (state == ST_IDLE) && start && !stop_req;
  assign step_go   = (state == ST_SWEEP) && expire && !stop_req && !end_sweep;

  // Decide the next frequency point and whether the sweep ends at this expiry.
  always_comb begin
    cur_tgt   = fwd ? cfg_stop : cfg_start;
    cur_up    = fwd ? cfg_up : ~cfg_up;
    at_target = (freq_ctrl == cur_tgt);
    end_sweep = cfg_degen ||
                (at_target && (cfg_mode != MODE_SAW) && (cfg_mode != MODE_TRI));
    nxt_freq  = step_clamp(freq_ctrl, cfg_step, cur_tgt, cur_up);
    nxt_fwd   = fwd;
    if (at_target && (cfg_mode == MODE_SAW)) begin
      nxt_freq = cfg_start;
    end else if (at_target && (cfg_mode == MODE_TRI)) begin
      // Leave the endpoint toward the opposite end without repeating it.
      nxt_fwd  = ~fwd;
      nxt_freq = step_clamp(freq_ctrl, cfg_step, fwd ? cfg_start : cfg_stop, ~cur_up);
    end
  end

  dds_dwell_timer #(
    .DWELL_BIT (DWELL_BIT)
  ) u_dwell_timer (
    .clk      (sclk),
    .rst_n    (rst_n),
    .clear    (stop_req),
    .load     (start_ok | step_go),
    .load_val (start_ok ? dwell_eff : cfg_dwell),
    .expire   (expire)
  );

  // Sweep FSM, captured configuration and registered outputs.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cfg_mode    <= '0;
      cfg_start   <= '0;
      cfg_stop    <= '0;
      cfg_step    <= '0;
      cfg_dwell   <= '0;
      cfg_up      <= 1'b0;
      cfg_degen   <= 1'b0;
      fwd         <= 1'b0;
      freq_ctrl   <= '0;
      dds_en      <= 1'b0;
      sweep_busy  <= 1'b0;
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      if (stop_req) begin
        state      <= ST_IDLE;
        dds_en     <= 1'b0;
        sweep_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_mode    <= mode;
              cfg_start   <= f_start;
              cfg_stop    <= f_stop;
              cfg_step    <= f_step;
              cfg_dwell   <= dwell_eff;
              cfg_up      <= (f_stop > f_start);
              cfg_degen   <= (f_step == '0) || (f_start == f_stop);
              fwd         <= 1'b1;
              freq_ctrl   <= f_start;
              dds_en      <= 1'b1;
              sweep_busy  <= 1'b1;
              step_strobe <= 1'b1;
              state       <= ST_SWEEP;
            end
          end
          ST_SWEEP: begin
            if (expire) begin
              if (end_sweep) begin
                state      <= ST_DONE;
                sweep_busy <= 1'b0;
                sweep_done <= 1'b1;
              end else begin
                freq_ctrl   <= nxt_freq;
                fwd         <= nxt_fwd;
                step_strobe <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl. A reference model lists the frequency points of
// a sweep from its configuration. It expands them into per-cycle expected
// output words {freq, dds_en, busy, strobe, done}, and every cycle after
// start is compared against that list.
module tb_dds_sweep_ctrl;

  localparam int FB = 26;
  localparam int DB = 24;
  localparam int W  = FB + 4;

  // clock / reset
  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic          start    = 1'b0;
  logic          stop_req = 1'b0;
  logic [1:0]    mode     = '0;
  logic [FB-1:0] f_start  = '0;
  logic [FB-1:0] f_stop   = '0;
  logic [FB-1:0] f_step   = '0;
  logic [DB-1:0] dwell    = '0;
  logic [FB-1:0] freq_ctrl;
  logic          dds_en;
  logic          sweep_busy;
  logic          step_strobe;
  logic          sweep_done;
  logic [1:0]    state_dbg;

  dds_sweep_ctrl #(.FREQ_BIT(FB), .DWELL_BIT(DB)) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .start       (start),
    .stop_req    (stop_req),
    .mode        (mode),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .freq_ctrl   (freq_ctrl),
    .dds_en      (dds_en),
    .sweep_busy  (sweep_busy),
    .step_strobe (step_strobe),
    .sweep_done  (sweep_done),
    .state_dbg   (state_dbg)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  longint        pts[$];
  logic [FB-1:0] last_freq = '0;

  // reference model: ordered list of presented frequency points
  task automatic build_points(input int md, input longint fs, input longint fe,
                              input longint st, input int max_pts);
    longint cur;
    longint tgt;
    bit     fwd;
    pts.delete();
    pts.push_back(fs);
    if (st == 0 || fs == fe) return;
    cur = fs;
    fwd = 1'b1;
    while (pts.size() < max_pts) begin
      tgt = fwd ? fe : fs;
      if (cur == tgt) begin
        if (md == 1) begin
          cur = fs;
          pts.push_back(cur);
          continue;
        end else if (md == 2) begin
          fwd = !fwd;
          tgt = fwd ? fe : fs;
        end else begin
          break;
        end
      end
      if (tgt > cur) cur = (cur + st >= tgt) ? tgt : cur + st;
      else           cur = (cur - st <= tgt) ? tgt : cur - st;
      pts.push_back(cur);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [FB-1:0] f, input logic en,
                                            input logic busy, input logic stb, input logic dn);
    return {f, en, busy, stb, dn};
  endfunction

  // Drive one sweep and compare every cycle against the model.
  // stop_at >= 0 raises stop_req during that cycle index.
  task automatic run_sweep(input string name, input int md, input longint fs,
                           input longint fe, input longint st, input int dw,
                           input int stop_at_in, input bit scramble);
    int           d;
    int           done_idx;
    int           stop_at;
    bit           finite;
    logic [W-1:0] got;
    logic [W-1:0] e;
    logic [FB-1:0] lastp;
    d       = (dw == 0) ? 1 : dw;
    stop_at = stop_at_in;
    finite  = !(md == 1 || md == 2) || st == 0 || fs == fe;
    build_points(md, fs, fe, st, finite ? 100000 : (stop_at / d + 2));
    exp_q.delete();
    foreach (pts[p]) begin
      for (int j = 0; j < d; j++) exp_q.push_back(pack_exp(FB'(pts[p]), 1'b1, 1'b1, j == 0, 1'b0));
    end
    lastp = FB'(pts[pts.size() - 1]);
    if (finite) begin
      exp_q.push_back(pack_exp(lastp, 1'b1, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(pack_exp(lastp, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    if (stop_at > exp_q.size() - 1) stop_at = -1;
    if (stop_at >= 0) begin
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      e = exp_q[stop_at];
      exp_q.push_back(pack_exp(e[W-1:4], 1'b0, 1'b0, 1'b0, 1'b0));
    end
    done_idx = finite ? pts.size() * d : (1 << 30);

    @(negedge sclk);
    mode = 2'(md); f_start = FB'(fs); f_stop = FB'(fe); f_step = FB'(st); dwell = DB'(dw);
    start = 1'b1; stop_req = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge sclk);
      got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
      e   = exp_q[i];
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got freq=%0h en=%b busy=%b stb=%b done=%b, want freq=%0h en=%b busy=%b stb=%b done=%b",
                 name, i, got[W-1:4], got[3], got[2], got[1], got[0], e[W-1:4], e[3], e[2], e[1], e[0]);
      end
      last_freq = e[W-1:4];
      start     = 1'b0;
      stop_req  = (i == stop_at);
      if (scramble) begin
        mode    = 2'($urandom_range(0, 3));
        f_start = FB'($urandom);
        f_stop  = FB'($urandom);
        f_step  = FB'($urandom_range(0, 50));
        dwell   = DB'($urandom_range(0, 5));
        if (i < done_idx && (stop_at < 0 || i < stop_at)) start = 1'($urandom_range(0, 1));
      end
    end
    start    = 1'b0;
    stop_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [W-1:0] got;
    repeat (3) @(negedge sclk);
    got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset: got %0h want 0", got);
    end
    rst_n = 1'b1;
    @(negedge sclk);
    got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %0h want 0", got);
    end
  endtask

  task automatic test_single_up;
    run_sweep("single_up", 0, 100, 130, 10, 3, -1, 1'b0);
  endtask

  task automatic test_clamp_down;
    run_sweep("clamp_up", 0, 0, 25, 10, 1, -1, 1'b0);
    run_sweep("down", 3, 50, 20, 15, 1, -1, 1'b0);
    run_sweep("underflow", 0, 16, 5, 32, 2, -1, 1'b0);
  endtask

  task automatic test_periodic;
    run_sweep("triangle", 2, 0, 20, 10, 1, 12, 1'b0);
    run_sweep("sawtooth", 1, 0, 20, 10, 1, 12, 1'b0);
    run_sweep("tri_down", 2, 90, 40, 20, 2, 25, 1'b0);
  endtask

  task automatic test_overflow;
    run_sweep("overflow", 0, 64'h3FFFFF0, 64'h3FFFFFF, 64'h20, 1, -1, 1'b0);
  endtask

  task automatic test_abort;
    run_sweep("abort", 0, 100, 130, 10, 3, 3, 1'b0);
  endtask

  // start and stop_req together in IDLE: nothing starts
  task automatic test_contention;
    logic [W-1:0] got;
    logic [W-1:0] e;
    @(negedge sclk);
    mode = 2'd0; f_start = FB'(77); f_stop = FB'(99); f_step = FB'(1); dwell = DB'(1);
    start = 1'b1; stop_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk);
      start = 1'b0; stop_req = 1'b0;
      got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
      e   = pack_exp(last_freq, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL contention cycle %0d: got %0h want %0h", i, got, e);
      end
    end
  endtask

  task automatic test_start_busy;
    run_sweep("start_busy", 0, 300, 200, 25, 2, -1, 1'b1);
  endtask

  task automatic test_degenerate;
    run_sweep("degen_step0", 1, 500, 900, 0, 4, -1, 1'b0);
    run_sweep("degen_span0", 2, 7, 7, 3, 0, -1, 1'b0);
  endtask

  task automatic test_random;
    int     md;
    longint fs;
    longint fe;
    longint st;
    int     dw;
    int     sa;
    for (int k = 0; k < 25; k++) begin
      md = $urandom_range(0, 3);
      fs = $urandom_range(0, 200);
      fe = $urandom_range(0, 200);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      dw = $urandom_range(0, 4);
      if (md == 1 || md == 2) sa = $urandom_range(10, 60);
      else sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run_sweep("random", md, fs, fe, st, dw, sa, 1'b1);
    end
  endtask

  // asynchronous reset mid-sweep clears outputs before the next edge
  task automatic test_reset_mid;
    logic [W-1:0] got;
    @(negedge sclk);
    mode = 2'd1; f_start = FB'(0); f_stop = FB'(1000); f_step = FB'(7); dwell = DB'(2);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
    repeat (5) @(negedge sclk);
    #2 rst_n = 1'b0;
    #1;
    got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0h want 0", got);
    end
    @(negedge sclk);
    rst_n = 1'b1;
    last_freq = '0;
    @(negedge sclk);
    got = {freq_ctrl, dds_en, sweep_busy, step_strobe, sweep_done};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %0h want 0", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_clamp_down();
    test_periodic();
    test_overflow();
    test_abort();
    test_contention();
    test_start_busy();
    test_degenerate();
    test_random();
    test_reset_mid();
    test_single_up();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
